code_entry: RTL

Operator code-entry front end for the combination lock. It conditions four raw push-buttons (up, down, select, next) and maintains the eight BCD digits currently showing on the displays. It drives the digit buses and a clean single-cycle `next_pulse` straight into the lock state manager's showing-digit and `button_next` inputs. It also exposes the cursor position for display highlighting.

---
 rtl/code_entry_pkg.sv | 32 +++
 rtl/code_entry_button_debouncer.sv | 93 +++++++++
 rtl/code_entry.sv | 80 ++++++++
 3 files changed

// File: rtl/code_entry_pkg.sv
// Shared types and constants for the operator code-entry front end.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package code_entry_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Button slots in the debouncer array
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_SEL  = 2;
    localparam int BTN_NEXT = 3;

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } deb_state_t;

    // BCD increment with 9 wrapping to 0
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    // BCD decrement with 0 wrapping to 9
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/code_entry_button_debouncer.sv
// One push-button: 2-flop synchronizer, debounce FSM, registered press pulse.
// Latency: pulse high in the cycle after edge E+1+DEBOUNCE_CYCLES (raw low before edge E).
// Backpressure: none; a held button yields exactly one pulse, no auto-repeat.
module button_debouncer
    import code_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The cycle that moves the FSM into a WAIT state already counts as the
    // first stable sample, so the wait states finish when the count reaches DEBOUNCE_CYCLES-2.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic          sync1;
    logic          sync2;
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;

    // Bring the asynchronous button into the clock domain; idle level is released (1)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // FSM state, qualification counter and press pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // Next-state logic: qualify a level change for DEBOUNCE_CYCLES stable samples
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync2) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (sync2) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (!sync2) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

endmodule

// File: rtl/code_entry.sv
// Code-entry front end: debounced buttons edit eight BCD digits under a cursor.
// Latency: edits visible one cycle after the press pulse; next_pulse coincides with it.
// Backpressure: none; edit pulses arriving while entry_en=0 are dropped, never queued.
module code_entry
    import code_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_sel_n,
    input  logic       btn_next_n,
    input  logic       entry_en,
    input  logic       clear,
    output logic [3:0] digit1_showing,
    output logic [3:0] digit2_showing,
    output logic [3:0] digit3_showing,
    output logic [3:0] digit4_showing,
    output logic [3:0] digit5_showing,
    output logic [3:0] digit6_showing,
    output logic [3:0] digit7_showing,
    output logic [3:0] digit8_showing,
    output logic [2:0] cursor,
    output logic       next_pulse
);

    logic [3:0]                 btn_raw;
    logic [3:0]                 press;
    logic [NUM_DIGITS-1:0][3:0] digits;

    assign btn_raw[BTN_UP]   = btn_up_n;
    assign btn_raw[BTN_DOWN] = btn_down_n;
    assign btn_raw[BTN_SEL]  = btn_sel_n;
    assign btn_raw[BTN_NEXT] = btn_next_n;

    for (genvar b = 0; b < 4; b++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn_n(btn_raw[b]),
            .press(press[b])
        );
    end

    // The debouncer's press output is already a flop, so this is glitch-free
    // and lands in the same cycle the edit pulses do.
    assign next_pulse = press[BTN_NEXT];

    // Digit register file and cursor; clear beats edits, up+down cancel,
    // and a coincident sel edits the old cursor position before advancing.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            digits <= '0;
            cursor <= '0;
        end else if (entry_en) begin
            if (press[BTN_UP] && !press[BTN_DOWN]) begin
                digits[cursor] <= bcd_inc(digits[cursor]);
            end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
                digits[cursor] <= bcd_dec(digits[cursor]);
            end
            if (press[BTN_SEL]) begin
                cursor <= cursor + 3'd1;
            end
        end
    end

    assign digit1_showing = digits[0];
    assign digit2_showing = digits[1];
    assign digit3_showing = digits[2];
    assign digit4_showing = digits[3];
    assign digit5_showing = digits[4];
    assign digit6_showing = digits[5];
    assign digit7_showing = digits[6];
    assign digit8_showing = digits[7];

endmodule
